// File: rtl/round_timer_controller.sv
// Round timer: a get-ready countdown followed by the round countdown. Supports pause
// and bonus time, and shows the time left as two BCD digits for the HEX0/HEX1 decoders.
module round_timer_controller #(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int ROUND_SECONDS   = 60,
   parameter int READY_SECONDS   = 3,
   parameter int BONUS_SECONDS   = 5
) (
   input  logic       ClockIn,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Pause,
   input  logic       Bonus,
   output logic [3:0] OnesValue,
   output logic [3:0] TensValue,
   output logic [2:0] State,
   output logic       Playing,
   output logic       SecondTick,
   output logic       GameOver
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READY   = 3'd1,
      PLAYING = 3'd2,
      PAUSED  = 3'd3,
      OVER    = 3'd4
   } state_t;

   localparam int PRESCALE_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
   localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(CLOCK_FREQUENCY - 1);
   localparam logic [PRESCALE_W-1:0] PRESCALE_ONE = PRESCALE_W'(1);
   localparam logic [3:0] ROUND_TENS   = 4'(ROUND_SECONDS / 10);
   localparam logic [3:0] ROUND_ONES   = 4'(ROUND_SECONDS % 10);
   localparam logic [3:0] READY_TENS   = 4'(READY_SECONDS / 10);
   localparam logic [3:0] READY_ONES   = 4'(READY_SECONDS % 10);
   localparam logic [7:0] BONUS_AMOUNT = 8'(BONUS_SECONDS);

   state_t                  state_q, state_d;
   logic [PRESCALE_W-1:0]   prescaler_q, prescaler_d;
   logic [3:0]              ones_q, ones_d, tens_q, tens_d;
   logic                    second_tick_q, second_tick_d;
   logic                    game_over_q, game_over_d;
   logic                    playing_q, playing_d;
   logic                    count_enable, tick, bonus_active;
   logic [7:0]              value_bin, stepped_value, next_value;

   function automatic logic [7:0] to_bcd(input logic [7:0] bin);
      logic [3:0] tens_digit;
      tens_digit = 4'(bin / 8'd10);
      return {tens_digit, 4'(bin - 8'(tens_digit) * 8'd10)};
   endfunction

   // The prescaler only runs while a countdown is live; pausing suppresses the tick.
   assign count_enable  = (state_q == READY) || ((state_q == PLAYING) && !Pause);
   assign tick          = count_enable && (prescaler_q == PRESCALE_MAX);
   assign bonus_active  = Bonus && ((state_q == PLAYING) || (state_q == PAUSED));

   // Tick and bonus share one saturating update so they combine on the same edge.
   assign value_bin     = {4'd0, tens_q} * 8'd10 + {4'd0, ones_q};
   assign stepped_value = value_bin - {7'd0, tick} + (bonus_active ? BONUS_AMOUNT : 8'd0);
   assign next_value    = (stepped_value > 8'd99) ? 8'd99 : stepped_value;

   always_comb begin
      state_d       = state_q;
      ones_d        = ones_q;
      tens_d        = tens_q;
      second_tick_d = 1'b0;
      game_over_d   = 1'b0;
      prescaler_d   = prescaler_q;
      if (count_enable) begin
         prescaler_d = (prescaler_q == PRESCALE_MAX) ? '0 : prescaler_q + PRESCALE_ONE;
      end

      case (state_q)
         IDLE, OVER: begin
            if (Start) begin
               state_d     = READY;
               tens_d      = READY_TENS;
               ones_d      = READY_ONES;
               prescaler_d = '0;
            end
         end
         READY: begin
            if (tick) begin
               second_tick_d = 1'b1;
               if (value_bin == 8'd1) begin
                  state_d = PLAYING;
                  tens_d  = ROUND_TENS;
                  ones_d  = ROUND_ONES;
               end else begin
                  {tens_d, ones_d} = to_bcd(next_value);
               end
            end
         end
         PLAYING: begin
            second_tick_d = tick;
            if (tick || bonus_active) begin
               {tens_d, ones_d} = to_bcd(next_value);
            end
            if (Pause) begin
               state_d = PAUSED;
            end else if (tick && (next_value == 8'd0)) begin
               state_d     = OVER;
               game_over_d = 1'b1;
            end
         end
         PAUSED: begin
            if (bonus_active) begin
               {tens_d, ones_d} = to_bcd(next_value);
            end
            if (!Pause) begin
               state_d = PLAYING;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      playing_d = (state_d == PLAYING);
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         state_q       <= IDLE;
         prescaler_q   <= '0;
         tens_q        <= ROUND_TENS;
         ones_q        <= ROUND_ONES;
         second_tick_q <= 1'b0;
         game_over_q   <= 1'b0;
         playing_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         prescaler_q   <= prescaler_d;
         tens_q        <= tens_d;
         ones_q        <= ones_d;
         second_tick_q <= second_tick_d;
         game_over_q   <= game_over_d;
         playing_q     <= playing_d;
      end
   end

   assign OnesValue  = ones_q;
   assign TensValue  = tens_q;
   assign State      = state_q;
   assign Playing    = playing_q;
   assign SecondTick = second_tick_q;
   assign GameOver   = game_over_q;

endmodule

// File: tb/tb_round_timer_controller.sv
// Bench for round_timer_controller: scenario tasks plus random play, all checked
// against an integer "seconds left" model of the game rules.
module tb_round_timer_controller;

   localparam int CF  = 4;
   localparam int RS  = 12;
   localparam int RDS = 3;
   localparam int BS  = 5;

   logic       ClockIn = 1'b0;
   logic       Reset = 1'b1, Start = 1'b0, Pause = 1'b0, Bonus = 1'b0;
   logic [3:0] OnesValue, TensValue;
   logic [2:0] State;
   logic       Playing, SecondTick, GameOver;

   int errors = 0;
   int checks = 0;

   // Model: mode 0..4, seconds left as a plain integer, cycles elapsed in the current second.
   int m_state = 0;
   int m_value = RS;
   int m_count = 0;
   bit m_tick  = 1'b0;
   bit m_over  = 1'b0;

   round_timer_controller #(
      .CLOCK_FREQUENCY(CF),
      .ROUND_SECONDS(RS),
      .READY_SECONDS(RDS),
      .BONUS_SECONDS(BS)
   ) dut (
      .ClockIn(ClockIn),
      .Reset(Reset),
      .Start(Start),
      .Pause(Pause),
      .Bonus(Bonus),
      .OnesValue(OnesValue),
      .TensValue(TensValue),
      .State(State),
      .Playing(Playing),
      .SecondTick(SecondTick),
      .GameOver(GameOver)
   );

   always #5 ClockIn = ~ClockIn;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int with_bonus(input int v);
      return (v + BS > 99) ? 99 : v + BS;
   endfunction

   function automatic logic [13:0] exp_vec();
      return {3'(m_state), 4'(m_value / 10), 4'(m_value % 10), (m_state == 2), m_tick, m_over};
   endfunction

   function automatic logic [13:0] dut_vec();
      return {State, TensValue, OnesValue, Playing, SecondTick, GameOver};
   endfunction

   task automatic model_step(input bit s, input bit p, input bit b, input bit r);
      int nv;
      bit t;
      m_tick = 1'b0;
      m_over = 1'b0;
      if (r) begin
         m_state = 0; m_value = RS; m_count = 0;
      end else begin
         case (m_state)
            0, 4: if (s) begin m_state = 1; m_value = RDS; m_count = 0; end
            1: begin
               if (m_count == CF - 1) begin
                  m_count = 0;
                  m_tick  = 1'b1;
                  if (m_value == 1) begin m_state = 2; m_value = RS; end
                  else m_value = m_value - 1;
               end else m_count++;
            end
            2: begin
               if (p) begin
                  m_state = 3;
                  if (b) m_value = with_bonus(m_value);
               end else begin
                  t = (m_count == CF - 1);
                  m_count = t ? 0 : m_count + 1;
                  nv = m_value - (t ? 1 : 0) + (b ? BS : 0);
                  if (nv > 99) nv = 99;
                  m_value = nv;
                  m_tick  = t;
                  if (t && nv == 0) begin m_state = 4; m_over = 1'b1; end
               end
            end
            3: begin
               if (b) m_value = with_bonus(m_value);
               if (!p) m_state = 2;
            end
            default: m_state = 0;
         endcase
      end
   endtask

   task automatic drive_cycle(input bit s, input bit p, input bit b, input bit r);
      Start = s; Pause = p; Bonus = b; Reset = r;
      model_step(s, p, b, r);
      @(posedge ClockIn);
      #1;
      Start = 1'b0; Bonus = 1'b0; Reset = 1'b0;
   endtask

   task automatic test_reset();
      drive_cycle(0, 0, 0, 1);
      drive_cycle(0, 0, 0, 1);
      checks++;
      if (dut_vec() !== {3'd0, 4'd1, 4'd2, 3'b000})
         begin errors++; $display("[TB] FAIL reset_state: got %h expected %h", dut_vec(), {3'd0, 4'd1, 4'd2, 3'b000}); end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(0, 0, 1, 0);
         checks++;
         if (dut_vec() !== exp_vec())
            begin errors++; $display("[TB] FAIL idle_hold: got %h expected %h", dut_vec(), exp_vec()); end
      end
   endtask

   task automatic test_ready_countdown();
      logic [7:0] want_digits [3] = '{8'h02, 8'h01, 8'h12};
      logic [2:0] want_state  [3] = '{3'd1, 3'd1, 3'd2};
      drive_cycle(1, 0, 0, 0);
      checks++;
      if ({State, TensValue, OnesValue} !== {3'd1, 8'h03})
         begin errors++; $display("[TB] FAIL ready_entry: got %h expected %h", {State, TensValue, OnesValue}, {3'd1, 8'h03}); end
      for (int i = 1; i <= 3 * CF; i++) begin
         drive_cycle(0, 0, 0, 0);
         checks++;
         if (dut_vec() !== exp_vec())
            begin errors++; $display("[TB] FAIL ready_cycle %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
         if (i % CF == 0) begin
            checks++;
            if ({State, TensValue, OnesValue, SecondTick} !== {want_state[i/CF-1], want_digits[i/CF-1], 1'b1})
               begin errors++; $display("[TB] FAIL ready_tick %0d: got %h expected %h", i / CF,
                     {State, TensValue, OnesValue, SecondTick}, {want_state[i/CF-1], want_digits[i/CF-1], 1'b1}); end
         end
      end
   endtask

   task automatic test_full_round();
      int over_pulses = 0;
      int tick_idx = 0;
      int want;
      for (int i = 0; i < RS * CF + 4; i++) begin
         drive_cycle(0, 0, 0, 0);
         checks++;
         if (dut_vec() !== exp_vec())
            begin errors++; $display("[TB] FAIL round_cycle %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
         if (GameOver === 1'b1) over_pulses++;
         if (SecondTick === 1'b1) begin
            want = RS - 1 - tick_idx;
            checks++;
            if ({TensValue, OnesValue} !== {4'(want / 10), 4'(want % 10)})
               begin errors++; $display("[TB] FAIL round_digits tick %0d: got %h expected %0d", tick_idx, {TensValue, OnesValue}, want); end
            tick_idx++;
         end
      end
      checks++;
      if (over_pulses !== 1)
         begin errors++; $display("[TB] FAIL gameover_pulses: got %0d expected 1", over_pulses); end
      checks++;
      if (tick_idx !== RS)
         begin errors++; $display("[TB] FAIL round_tick_count: got %0d expected %0d", tick_idx, RS); end
      checks++;
      if ({State, TensValue, OnesValue} !== {3'd4, 8'h00})
         begin errors++; $display("[TB] FAIL over_hold: got %h expected %h", {State, TensValue, OnesValue}, {3'd4, 8'h00}); end
   endtask

   task automatic test_pause();
      int held, frozen, stray_ticks, n;
      drive_cycle(1, 0, 0, 0);
      for (int i = 0; i < 3 * CF + 6; i++) drive_cycle(0, 0, 0, 0);
      frozen = m_value;
      stray_ticks = 0;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(0, 1, 0, 0);
         if (SecondTick !== 1'b0) stray_ticks++;
         checks++;
         if ({State, TensValue, OnesValue} !== {3'd3, 4'(frozen / 10), 4'(frozen % 10)})
            begin errors++; $display("[TB] FAIL pause_frozen %0d: got %h expected state 3 value %0d", i, {State, TensValue, OnesValue}, frozen); end
      end
      checks++;
      if (stray_ticks !== 0)
         begin errors++; $display("[TB] FAIL pause_ticks: got %0d expected 0", stray_ticks); end
      held = m_count;
      drive_cycle(0, 0, 0, 0);
      n = 0;
      while (SecondTick !== 1'b1 && n < 3 * CF) begin
         drive_cycle(0, 0, 0, 0);
         n++;
      end
      checks++;
      if (n !== CF - held)
         begin errors++; $display("[TB] FAIL resume_latency: got %0d expected %0d", n, CF - held); end
   endtask

   task automatic test_bonus();
      int guard = 0;
      while (!(m_state == 2 && m_value == 1 && m_count == CF - 1) && guard < 400) begin
         drive_cycle(0, 0, 0, 0); guard++;
      end
      drive_cycle(0, 0, 1, 0);
      checks++;
      if ({State, TensValue, OnesValue, GameOver} !== {3'd2, 8'h05, 1'b0})
         begin errors++; $display("[TB] FAIL bonus_on_tick: got %h expected %h", {State, TensValue, OnesValue, GameOver}, {3'd2, 8'h05, 1'b0}); end
      guard = 0;
      while (m_value != 2 && guard < 100) begin
         drive_cycle(0, 0, 0, 0); guard++;
      end
      drive_cycle(0, 1, 0, 0);
      for (int i = 0; i < 19; i++) drive_cycle(0, 1, 1, 0);
      checks++;
      if ({State, TensValue, OnesValue} !== {3'd3, 8'h97})
         begin errors++; $display("[TB] FAIL bonus_to_97: got %h expected %h", {State, TensValue, OnesValue}, {3'd3, 8'h97}); end
      drive_cycle(0, 1, 1, 0);
      checks++;
      if ({TensValue, OnesValue} !== 8'h99)
         begin errors++; $display("[TB] FAIL bonus_saturate: got %h expected 99", {TensValue, OnesValue}); end
      drive_cycle(0, 0, 0, 1);
      drive_cycle(0, 0, 1, 0);
      checks++;
      if ({State, TensValue, OnesValue} !== {3'd0, 8'h12})
         begin errors++; $display("[TB] FAIL bonus_idle: got %h expected %h", {State, TensValue, OnesValue}, {3'd0, 8'h12}); end
      drive_cycle(1, 0, 0, 0);
      drive_cycle(0, 0, 1, 0);
      drive_cycle(1, 1, 0, 0);
      checks++;
      if ({State, TensValue, OnesValue} !== {3'd1, 8'h03})
         begin errors++; $display("[TB] FAIL ready_ignores_inputs: got %h expected %h", {State, TensValue, OnesValue}, {3'd1, 8'h03}); end
      checks++;
      if (dut_vec() !== exp_vec())
         begin errors++; $display("[TB] FAIL bonus_model: got %h expected %h", dut_vec(), exp_vec()); end
   endtask

   task automatic test_start_ignored();
      int guard = 0;
      drive_cycle(0, 0, 0, 1);
      drive_cycle(1, 0, 0, 0);
      for (int i = 0; i < 3 * CF + 2; i++) drive_cycle(0, 0, 0, 0);
      drive_cycle(1, 0, 0, 0);
      checks++;
      if (dut_vec() !== exp_vec() || State !== 3'd2)
         begin errors++; $display("[TB] FAIL start_in_playing: got %h expected %h", dut_vec(), exp_vec()); end
      while (m_state != 4 && guard < 200) begin
         drive_cycle(0, 0, 0, 0); guard++;
      end
      checks++;
      if (guard >= 200)
         begin errors++; $display("[TB] FAIL reach_over: got timeout expected OVER"); end
      drive_cycle(1, 0, 0, 0);
      checks++;
      if ({State, TensValue, OnesValue} !== {3'd1, 8'h03})
         begin errors++; $display("[TB] FAIL restart_from_over: got %h expected %h", {State, TensValue, OnesValue}, {3'd1, 8'h03}); end
   endtask

   task automatic test_reset_mid_round();
      drive_cycle(0, 0, 0, 1);
      drive_cycle(1, 0, 0, 0);
      for (int i = 0; i < 3 * CF + 5; i++) drive_cycle(0, 0, 0, 0);
      drive_cycle(0, 0, 0, 1);
      checks++;
      if (dut_vec() !== {3'd0, 8'h12, 3'b000})
         begin errors++; $display("[TB] FAIL reset_in_playing: got %h expected %h", dut_vec(), {3'd0, 8'h12, 3'b000}); end
      drive_cycle(1, 0, 0, 0);
      for (int i = 0; i < 3 * CF + 2; i++) drive_cycle(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 0);
      drive_cycle(0, 1, 0, 1);
      checks++;
      if (dut_vec() !== {3'd0, 8'h12, 3'b000})
         begin errors++; $display("[TB] FAIL reset_in_paused: got %h expected %h", dut_vec(), {3'd0, 8'h12, 3'b000}); end
   endtask

   task automatic test_random();
      bit p = 1'b0;
      bit s, b, r;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 14) == 0) p = ~p;
         s = ($urandom_range(0, 19) == 0);
         b = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 299) == 0);
         drive_cycle(s, p, b, r);
         checks++;
         if (dut_vec() !== exp_vec())
            begin errors++; $display("[TB] FAIL random cycle %0d: got %h expected %h", i, dut_vec(), exp_vec()); end
      end
   endtask

   initial begin
      test_reset();
      test_ready_countdown();
      test_full_round();
      test_pause();
      test_bonus();
      test_start_ignored();
      test_reset_mid_round();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
